// File: rtl/fetch_unit_pkg.sv
// Shared constants for the LEGv8 fetch stage: FSM encodings, halt sentinel,
// opcode field bounds and the branch-target alignment mask.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_EXEC  = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_0000;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 21;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating retired-instruction and memory-stall counters for fetch_unit;
// only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_retired,
    input  logic        inc_stall,
    output logic [31:0] perf_retired,
    output logic [31:0] perf_stall
);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_retired <= '0;
            perf_stall   <= '0;
        end else begin
            if (inc_retired && (perf_retired != '1)) begin
                perf_retired <= perf_retired + 32'd1;
            end
            if (inc_stall && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the non-pipelined LEGv8 core: PC ownership, imem
// handshake, instruction hold for decode, halt/misalignment detection.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned             PC_WIDTH    = 64,
    parameter int unsigned             INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]  HALT_WORD   = INSTR_WIDTH'(HALT_WORD_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [10:0]            opcode,
    output logic                   instr_valid,
    input  logic                   instr_ack,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    pc_plus4,
    output logic                   halted,
    output logic                   fault,
    output logic [31:0]            perf_retired,
    output logic [31:0]            perf_stall
);

    state_t                 state;
    state_t                 state_next;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [PC_WIDTH-1:0]    pc_next;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [INSTR_WIDTH-1:0] instr_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state   <= state_next;
            pc_q    <= pc_next;
            instr_q <= instr_next;
        end
    end

    assign pc_plus4 = pc_q + PC_WIDTH'(4);

    always_comb begin
        state_next  = state;
        pc_next     = pc_q;
        instr_next  = instr_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        case (state)
            S_REQ: begin
                // Gated by reset so the request is low during the reset cycle itself.
                imem_req = !reset;
                if (imem_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_next = imem_rdata;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                if (instr_ack) begin
                    if (instr_q == HALT_WORD) begin
                        state_next = S_HALT;
                    end else if (branch_taken && is_misaligned(branch_target[1:0])) begin
                        state_next = S_FAULT;
                    end else begin
                        pc_next    = branch_taken ? branch_target : pc_plus4;
                        state_next = S_REQ;
                    end
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_next = S_FAULT;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign opcode    = instr_q[OPCODE_MSB:OPCODE_LSB];

`ifdef FETCH_PERF_CNT_EN
    logic inc_retired;
    logic inc_stall;

    assign inc_retired = (state == S_EXEC) && instr_ack;
    assign inc_stall   = ((state == S_REQ) && !imem_ready) ||
                         ((state == S_WAIT) && !imem_rvalid);

    fetch_perf_counters u_perf (
        .clk          (clk),
        .reset        (reset),
        .inc_retired  (inc_retired),
        .inc_stall    (inc_stall),
        .perf_retired (perf_retired),
        .perf_stall   (perf_stall)
    );
`else
    assign perf_retired = '0;
    assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a bench-side PC model pushes expected
// {pc, word} pairs when memory accepts a request; they are popped when instr_valid rises.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [10:0] opcode;
    logic        instr_valid;
    logic        instr_ack;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        halted;
    logic        fault;
    logic [31:0] perf_retired;
    logic [31:0] perf_stall;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] word;
    } fetch_t;

    fetch_t      sb[$];
    fetch_t      e;
    logic [63:0] tb_pc;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_WIDTH    (64),
        .INSTR_WIDTH (32),
        .RESET_PC    (64'h0),
        .HALT_WORD   (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .instr_ack     (instr_ack),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .halted        (halted),
        .fault         (fault),
        .perf_retired  (perf_retired),
        .perf_stall    (perf_stall)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
        #1;
        tb_pc = 64'h0;
        sb.delete();
    endtask

    // Memory-side driver: waits (bounded) for a request, stalls ready, then rvalid.
    task automatic serve(input int rdly, input int vdly, input logic [31:0] data,
                         output bit ok, output logic [63:0] acc_addr,
                         output bit stable, output logic early_valid);
        int n = 0;
        ok = 1'b1;
        stable = 1'b1;
        early_valid = 1'bx;
        acc_addr = 'x;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (imem_req !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        acc_addr = imem_addr;
        repeat (rdly) begin
            imem_ready = 1'b0;
            step();
            if (imem_addr !== acc_addr || imem_req !== 1'b1) stable = 1'b0;
        end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        early_valid = instr_valid;
        repeat (vdly) step();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    endtask

    task automatic do_ack(input logic taken, input logic [63:0] tgt);
        instr_ack     = 1'b1;
        branch_taken  = taken;
        branch_target = tgt;
        step();
        instr_ack     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        step();
        checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
        checks++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr: got %h/%b want 0/0", instr, instr_valid); end
        checks++; if (halted !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b want 00", halted, fault); end
        checks++; if (perf_retired !== 32'h0 || perf_stall !== 32'h0) begin errors++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_retired, perf_stall); end
        reset = 1'b0;
        #1;
        tb_pc = 64'h0;
        sb.delete();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("FAIL post_reset_req: got %b@%h want 1@0", imem_req, imem_addr); end
    endtask

    task automatic test_basic();
        bit ok, stable; logic [63:0] a; logic ev; logic [31:0] w;
        sb.push_back('{addr: tb_pc, word: 32'h8B02_0020});
        serve(0, 0, 32'h8B02_0020, ok, a, stable, ev);
        checks++; if (!ok || a !== 64'h0) begin errors++; $display("FAIL basic_addr: got %h ok=%b want 0", a, ok); end
        checks++; if (ev !== 1'b0 || instr_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got early=%b valid=%b want 0/1", ev, instr_valid); end
        e = sb.pop_front();
        w = e.word;
        checks++; if (instr !== e.word || pc !== e.addr) begin errors++; $display("FAIL basic_instr: got %h@%h want %h@%h", instr, pc, e.word, e.addr); end
        checks++; if (opcode !== w[31:21] || opcode !== 11'h458) begin errors++; $display("FAIL basic_opcode: got %h want 458", opcode); end
        step();
        checks++; if (instr_valid !== 1'b1 || instr !== e.word) begin errors++; $display("FAIL basic_hold: got %b/%h want 1/%h", instr_valid, instr, e.word); end
        do_ack(1'b0, 64'h0);
        tb_pc = tb_pc + 64'd4;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== tb_pc) begin errors++; $display("FAIL basic_next: got v=%b req=%b addr=%h want 0/1/%h", instr_valid, imem_req, imem_addr, tb_pc); end
    endtask

    task automatic test_stall();
        bit ok, stable; logic [63:0] a; logic ev;
        apply_reset(2);
        sb.push_back('{addr: tb_pc, word: 32'hD280_0021});
        serve(5, 2, 32'hD280_0021, ok, a, stable, ev);
        checks++; if (!ok || !stable || a !== tb_pc) begin errors++; $display("FAIL stall_addr: got %h stable=%b want %h stable=1", a, stable, tb_pc); end
        e = sb.pop_front();
        checks++; if (instr_valid !== 1'b1 || instr !== e.word) begin errors++; $display("FAIL stall_instr: got %b/%h want 1/%h", instr_valid, instr, e.word); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_stall !== 32'd7) begin errors++; $display("FAIL stall_count: got %0d want 7", perf_stall); end
`else
        checks++; if (perf_stall !== 32'd0) begin errors++; $display("FAIL stall_count: got %0d want 0", perf_stall); end
`endif
    endtask

    task automatic test_branch();
        bit ok, stable; logic [63:0] a; logic ev;
        do_ack(1'b1, 64'h100);
        tb_pc = 64'h100;
        checks++; if (imem_addr !== tb_pc || imem_req !== 1'b1) begin errors++; $display("FAIL branch_redirect: got %h want %h", imem_addr, tb_pc); end
        do_ack(1'b1, 64'h200);
        checks++; if (imem_addr !== tb_pc) begin errors++; $display("FAIL branch_ack_ignored: got %h want %h", imem_addr, tb_pc); end
        sb.push_back('{addr: tb_pc, word: 32'h1400_0010});
        serve(1, 1, 32'h1400_0010, ok, a, stable, ev);
        e = sb.pop_front();
        checks++; if (!ok || a !== e.addr || pc !== e.addr) begin errors++; $display("FAIL branch_fetch: got %h/%h want %h", a, pc, e.addr); end
        checks++; if (pc_plus4 !== e.addr + 64'd4) begin errors++; $display("FAIL branch_plus4: got %h want %h", pc_plus4, e.addr + 64'd4); end
    endtask

    task automatic test_wrap();
        bit ok, stable; logic [63:0] a; logic ev;
        do_ack(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        tb_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        sb.push_back('{addr: tb_pc, word: 32'hAA01_0000});
        serve(0, 0, 32'hAA01_0000, ok, a, stable, ev);
        e = sb.pop_front();
        checks++; if (!ok || pc !== e.addr || pc_plus4 !== 64'h0) begin errors++; $display("FAIL wrap_plus4: got %h/%h want %h/0", pc, pc_plus4, e.addr); end
        do_ack(1'b0, 64'h0);
        tb_pc = tb_pc + 64'd4;
        checks++; if (imem_addr !== tb_pc || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_next: got %h want %h", imem_addr, tb_pc); end
    endtask

    task automatic test_fault();
        bit ok, stable; logic [63:0] a; logic ev; bit quiet = 1'b1;
        sb.push_back('{addr: tb_pc, word: 32'hB400_0040});
        serve(0, 0, 32'hB400_0040, ok, a, stable, ev);
        e = sb.pop_front();
        checks++; if (!ok || instr !== e.word) begin errors++; $display("FAIL fault_fetch: got %h want %h", instr, e.word); end
        do_ack(1'b1, 64'h102);
        checks++; if (fault !== 1'b1 || pc !== tb_pc || halted !== 1'b0) begin errors++; $display("FAIL fault_set: got f=%b h=%b pc=%h want 1/0/%h", fault, halted, pc, tb_pc); end
        do_ack(1'b1, 64'h300);
        repeat (10) begin
            step();
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b1 || pc !== tb_pc) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL fault_sticky: got quiet=%b want 1", quiet); end
    endtask

    task automatic test_halt();
        bit ok, stable; logic [63:0] a; logic ev; bit quiet = 1'b1; int retired = 0;
        apply_reset(1);
        sb.push_back('{addr: tb_pc, word: 32'h0000_0000});
        serve(0, 0, 32'h0000_0000, ok, a, stable, ev);
        e = sb.pop_front();
        checks++; if (!ok || instr_valid !== 1'b1 || instr !== e.word) begin errors++; $display("FAIL halt_fetch: got %b/%h want 1/%h", instr_valid, instr, e.word); end
        do_ack(1'b1, 64'h102);
        retired++;
        checks++; if (halted !== 1'b1 || fault !== 1'b0 || pc !== tb_pc) begin errors++; $display("FAIL halt_set: got h=%b f=%b pc=%h want 1/0/%h", halted, fault, pc, tb_pc); end
        repeat (10) begin
            step();
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL halt_sticky: got quiet=%b want 1", quiet); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_retired !== 32'(retired)) begin errors++; $display("FAIL halt_retired: got %0d want %0d", perf_retired, retired); end
`else
        checks++; if (perf_retired !== 32'd0) begin errors++; $display("FAIL halt_retired: got %0d want 0", perf_retired); end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok, stable; logic [63:0] a; logic ev;
        apply_reset(1);
        do_ack(1'b1, 64'h40);
        do_ack(1'b0, 64'h0);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_wait: got req=%b v=%b want 0/0", imem_req, instr_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        tb_pc = 64'h0;
        checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL mid_stale: got v=%b instr=%h want 0/0", instr_valid, instr); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== tb_pc || pc !== tb_pc) begin errors++; $display("FAIL mid_rereq: got req=%b addr=%h want 1/%h", imem_req, imem_addr, tb_pc); end
        sb.push_back('{addr: tb_pc, word: 32'h9100_0421});
        serve(0, 0, 32'h9100_0421, ok, a, stable, ev);
        e = sb.pop_front();
        checks++; if (!ok || instr !== e.word || pc !== e.addr) begin errors++; $display("FAIL mid_fresh: got %h@%h want %h@%h", instr, pc, e.word, e.addr); end
    endtask

    initial begin
        reset         = 1'b1;
        imem_ready    = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        instr_ack     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        tb_pc         = '0;
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_wrap();
        test_fault();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
